// File: rtl/kf8254_pkg.sv
// Shared field positions and encodings for the 8254 control/mode word.
package kf8254_pkg;
  localparam int SC_MSB = 7;
  localparam int SC_LSB = 6;
  localparam int RW_MSB = 5;
  localparam int RW_LSB = 4;

  localparam logic [1:0] SC_READ_BACK = 2'b11;
  localparam logic [1:0] RW_LATCH     = 2'b00;

  // Read-back word: both flags are active low, counter selects start at bit 1.
  localparam int RB_COUNT_N_BIT  = 5;
  localparam int RB_STATUS_N_BIT = 4;
  localparam int RB_SEL_LSB      = 1;
endpackage

// File: rtl/kf8254_strobe_sync.sv
// Optional synchroniser plus edge detect for one bus strobe; stays disarmed
// after reset until the strobe has been seen idle.
module kf8254_strobe_sync #(
  parameter int SYNC_STAGES = 0
) (
  input  logic clock,
  input  logic reset,
  input  logic strobe,
  output logic active,
  output logic rise,
  output logic fall
);
  logic armed, gated, prev;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)        armed <= 1'b0;
    else if (!strobe) armed <= 1'b1;
  end

  // Gating before the delay line keeps an access in flight at reset release
  // from ever appearing as an edge downstream.
  assign gated = strobe & armed;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign active = gated;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] shreg;
      if (SYNC_STAGES == 1) begin : g_one
        always_ff @(posedge clock or posedge reset) begin
          if (reset) shreg <= '0;
          else       shreg <= gated;
        end
      end else begin : g_multi
        always_ff @(posedge clock or posedge reset) begin
          if (reset) shreg <= '0;
          else       shreg <= {shreg[SYNC_STAGES-2:0], gated};
        end
      end
      assign active = shreg[SYNC_STAGES-1];
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) prev <= 1'b0;
    else       prev <= active;
  end

  assign rise = active & ~prev;
  assign fall = ~active & prev;
endmodule

// File: rtl/kf8254_control_logic.sv
// Bus front end of the 8254: decodes reads/writes into per-counter strobes.
module kf8254_control_logic
  import kf8254_pkg::*;
#(
  parameter int NUM_COUNTERS = 3,
  parameter int ADDR_WIDTH   = 2,
  parameter int SYNC_STAGES  = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    chip_select_n,
  input  logic                    read_enable_n,
  input  logic                    write_enable_n,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [7:0]              data_bus_in,
  output logic [7:0]              internal_data_bus,
  output logic [NUM_COUNTERS-1:0] write_control,
  output logic [NUM_COUNTERS-1:0] write_counter,
  output logic [NUM_COUNTERS-1:0] latch_count,
  output logic [NUM_COUNTERS-1:0] latch_status,
  output logic [NUM_COUNTERS-1:0] read_counter,
  output logic [NUM_COUNTERS-1:0] read_done,
  output logic                    illegal_access
);
  localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR = ADDR_WIDTH'(NUM_COUNTERS);

  logic wr_s, wr_fall, unused_wr_rise;
  logic rd_s, rd_rise, rd_fall;
  logic clash, blocked;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic [1:0] sc, rw;
  logic [NUM_COUNTERS-1:0] wc_d, wn_d, lc_d, ls_d, rc_d, rd_d;
  logic ill_d;

  kf8254_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_wr_sync (
    .clock(clock), .reset(reset),
    .strobe(~chip_select_n & ~write_enable_n),
    .active(wr_s), .rise(unused_wr_rise), .fall(wr_fall)
  );

  kf8254_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rd_sync (
    .clock(clock), .reset(reset),
    .strobe(~chip_select_n & ~read_enable_n),
    .active(rd_s), .rise(rd_rise), .fall(rd_fall)
  );

  assign sc = internal_data_bus[SC_MSB:SC_LSB];
  assign rw = internal_data_bus[RW_MSB:RW_LSB];
  // Once read and write overlap, both accesses are dead until the bus idles.
  assign blocked = clash | (rd_s & wr_s);

  always_comb begin
    wc_d  = '0;
    wn_d  = '0;
    lc_d  = '0;
    ls_d  = '0;
    rd_d  = '0;
    rc_d  = read_counter;
    ill_d = rd_s & wr_s & ~clash;

    if (wr_fall && !blocked) begin
      if (wr_addr < CTRL_ADDR) begin
        for (int i = 0; i < NUM_COUNTERS; i++) wn_d[i] = (int'(wr_addr) == i);
      end else if (wr_addr == CTRL_ADDR) begin
        if (sc == SC_READ_BACK) begin
          for (int i = 0; i < NUM_COUNTERS; i++) begin
            lc_d[i] = internal_data_bus[RB_SEL_LSB+i] & ~internal_data_bus[RB_COUNT_N_BIT];
            ls_d[i] = internal_data_bus[RB_SEL_LSB+i] & ~internal_data_bus[RB_STATUS_N_BIT];
          end
        end else if (int'(sc) < NUM_COUNTERS) begin
          for (int i = 0; i < NUM_COUNTERS; i++) begin
            if (int'(sc) == i) begin
              if (rw == RW_LATCH) lc_d[i] = 1'b1;
              else                wc_d[i] = 1'b1;
            end
          end
        end else begin
          ill_d = 1'b1;
        end
      end else begin
        ill_d = 1'b1;
      end
    end

    if (rd_fall && !blocked && (read_counter != '0))
      for (int i = 0; i < NUM_COUNTERS; i++) rd_d[i] = (int'(rd_addr) == i);
    if (rd_fall || blocked) rc_d = '0;

    if (rd_rise && !blocked) begin
      if (address < CTRL_ADDR)
        for (int i = 0; i < NUM_COUNTERS; i++) rc_d[i] = (int'(address) == i);
      else
        ill_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      internal_data_bus <= '0;
      wr_addr           <= '0;
      rd_addr           <= '0;
      clash             <= 1'b0;
      write_control     <= '0;
      write_counter     <= '0;
      latch_count       <= '0;
      latch_status      <= '0;
      read_counter      <= '0;
      read_done         <= '0;
      illegal_access    <= 1'b0;
    end else begin
      if (wr_s) begin
        internal_data_bus <= data_bus_in;
        wr_addr           <= address;
      end
      if (rd_rise) rd_addr <= address;
      clash          <= (rd_s & wr_s) | (clash & (rd_s | wr_s));
      write_control  <= wc_d;
      write_counter  <= wn_d;
      latch_count    <= lc_d;
      latch_status   <= ls_d;
      read_counter   <= rc_d;
      read_done      <= rd_d;
      illegal_access <= ill_d;
    end
  end
endmodule

// File: tb/tb_kf8254_control_logic.sv
// Two configurations (3 counters/no sync, 2 counters/2 sync stages) on one bus,
// compared cycle by cycle against a schedule of expected pulses.
module tb_kf8254_control_logic;
  localparam int CYC = 4096;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic chip_select_n = 1'b1, read_enable_n = 1'b1, write_enable_n = 1'b1;
  logic [1:0] address = '0;
  logic [7:0] data_bus_in = '0;

  logic [7:0] idb0, idb1;
  logic [2:0] wc0, wn0, lc0, ls0, rc0, rd0;
  logic [1:0] wc1, wn1, lc1, ls1, rc1, rd1;
  logic ill0, ill1;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  int e_wc[2][CYC], e_wn[2][CYC], e_lc[2][CYC], e_ls[2][CYC];
  int e_rc[2][CYC], e_rd[2][CYC], e_ill[2][CYC];

  kf8254_control_logic #(.NUM_COUNTERS(3), .ADDR_WIDTH(2), .SYNC_STAGES(0)) dut0 (
    .clock(clock), .reset(reset), .chip_select_n(chip_select_n),
    .read_enable_n(read_enable_n), .write_enable_n(write_enable_n),
    .address(address), .data_bus_in(data_bus_in), .internal_data_bus(idb0),
    .write_control(wc0), .write_counter(wn0), .latch_count(lc0),
    .latch_status(ls0), .read_counter(rc0), .read_done(rd0), .illegal_access(ill0)
  );

  kf8254_control_logic #(.NUM_COUNTERS(2), .ADDR_WIDTH(2), .SYNC_STAGES(2)) dut1 (
    .clock(clock), .reset(reset), .chip_select_n(chip_select_n),
    .read_enable_n(read_enable_n), .write_enable_n(write_enable_n),
    .address(address), .data_bus_in(data_bus_in), .internal_data_bus(idb1),
    .write_control(wc1), .write_counter(wn1), .latch_count(lc1),
    .latch_status(ls1), .read_counter(rc1), .read_done(rd1), .illegal_access(ill1)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic int nc(input int d);
    return (d == 0) ? 3 : 2;
  endfunction

  function automatic int ss(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Write whose strobe is released after edge b: one pulse SYNC+1 edges later.
  task automatic sched_write(input int d, input int b, input int addr, input logic [7:0] data);
    int t, n, sc, rw;
    t  = b + 1 + ss(d);
    n  = nc(d);
    sc = int'(data[7:6]);
    rw = int'(data[5:4]);
    if (addr < n) e_wn[d][t] |= (1 << addr);
    else if (addr == n) begin
      if (sc == 3) begin
        for (int i = 0; i < n; i++) begin
          if (data[1+i]) begin
            if (!data[5]) e_lc[d][t] |= (1 << i);
            if (!data[4]) e_ls[d][t] |= (1 << i);
          end
        end
      end else if (sc < n) begin
        if (rw == 0) e_lc[d][t] |= (1 << sc);
        else         e_wc[d][t] |= (1 << sc);
      end else e_ill[d][t] = 1;
    end else e_ill[d][t] = 1;
  endtask

  task automatic sched_read(input int d, input int a, input int len, input int addr);
    int s;
    s = ss(d);
    if (addr < nc(d)) begin
      for (int t = a + 1 + s; t <= a + len + s; t++) e_rc[d][t] = (1 << addr);
      e_rd[d][a + len + 1 + s] = (1 << addr);
    end else e_ill[d][a + 1 + s] = 1;
  endtask

  task automatic idle_gap();
    repeat (5 + $urandom_range(0, 2)) @(posedge clock);
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [7:0] data, input int len);
    int a;
    @(posedge clock); #1;
    address = addr; data_bus_in = data;
    chip_select_n = 1'b0; write_enable_n = 1'b0;
    a = cyc;
    for (int d = 0; d < 2; d++) sched_write(d, a + len, int'(addr), data);
    repeat (len) @(posedge clock);
    #1 write_enable_n = 1'b1; chip_select_n = 1'b1;
    idle_gap();
    chk($sformatf("idb0_after_wr_%0h", data), 32'(idb0), 32'(data));
    chk($sformatf("idb1_after_wr_%0h", data), 32'(idb1), 32'(data));
  endtask

  task automatic bus_read(input logic [1:0] addr, input int len);
    int a;
    @(posedge clock); #1;
    address = addr;
    chip_select_n = 1'b0; read_enable_n = 1'b0;
    a = cyc;
    for (int d = 0; d < 2; d++) sched_read(d, a, len, int'(addr));
    repeat (len) @(posedge clock);
    #1 read_enable_n = 1'b1; chip_select_n = 1'b1;
    idle_gap();
  endtask

  // Read started while a write is held: one illegal pulse, nothing else.
  task automatic bus_conflict();
    int c;
    @(posedge clock); #1;
    address = 2'd0; data_bus_in = 8'hA5;
    chip_select_n = 1'b0; write_enable_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 read_enable_n = 1'b0;
    c = cyc;
    for (int d = 0; d < 2; d++) e_ill[d][c + 1 + ss(d)] = 1;
    repeat (3) @(posedge clock);
    #1 read_enable_n = 1'b1; write_enable_n = 1'b1; chip_select_n = 1'b1;
    repeat (7) @(posedge clock);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_idb0"}, 32'(idb0), 0);
    chk({tag, "_idb1"}, 32'(idb1), 0);
    chk({tag, "_pulses0"}, 32'({wc0, wn0, lc0, ls0, rd0, ill0}), 0);
    chk({tag, "_pulses1"}, 32'({wc1, wn1, lc1, ls1, rd1, ill1}), 0);
    chk({tag, "_rc0"}, 32'(rc0), 0);
    chk({tag, "_rc1"}, 32'(rc1), 0);
  endtask

  // Async reset mid-read, then a write held low across reset release.
  task automatic reset_in_flight();
    mon_en = 1'b0;
    @(posedge clock); #1;
    address = 2'd0; chip_select_n = 1'b0; read_enable_n = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    chk("pre_rst_rc0", 32'(rc0), 1);
    chk("pre_rst_rc1", 32'(rc1), 1);
    #2 reset = 1'b1;
    #1 chk_all_zero("async_rst");
    read_enable_n = 1'b1; write_enable_n = 1'b0; data_bus_in = 8'h55;
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    mon_en = 1'b1;
    repeat (4) @(posedge clock);
    #1 write_enable_n = 1'b1; chip_select_n = 1'b1;
    repeat (8) @(posedge clock);
  endtask

  always @(negedge clock) begin
    if (mon_en && cyc < CYC) begin
      chk($sformatf("wc0@%0d", cyc), 32'(wc0), e_wc[0][cyc]);
      chk($sformatf("wn0@%0d", cyc), 32'(wn0), e_wn[0][cyc]);
      chk($sformatf("lc0@%0d", cyc), 32'(lc0), e_lc[0][cyc]);
      chk($sformatf("ls0@%0d", cyc), 32'(ls0), e_ls[0][cyc]);
      chk($sformatf("rc0@%0d", cyc), 32'(rc0), e_rc[0][cyc]);
      chk($sformatf("rd0@%0d", cyc), 32'(rd0), e_rd[0][cyc]);
      chk($sformatf("ill0@%0d", cyc), 32'(ill0), e_ill[0][cyc]);
      chk($sformatf("wc1@%0d", cyc), 32'(wc1), e_wc[1][cyc]);
      chk($sformatf("wn1@%0d", cyc), 32'(wn1), e_wn[1][cyc]);
      chk($sformatf("lc1@%0d", cyc), 32'(lc1), e_lc[1][cyc]);
      chk($sformatf("ls1@%0d", cyc), 32'(ls1), e_ls[1][cyc]);
      chk($sformatf("rc1@%0d", cyc), 32'(rc1), e_rc[1][cyc]);
      chk($sformatf("rd1@%0d", cyc), 32'(rd1), e_rd[1][cyc]);
      chk($sformatf("ill1@%0d", cyc), 32'(ill1), e_ill[1][cyc]);
    end
  end

  initial begin
    #3 chk_all_zero("reset");
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    mon_en = 1'b1;

    bus_write(2'd3, 8'h34, 2);
    bus_write(2'd3, 8'hC2, 1);
    bus_write(2'd3, 8'h80, 3);
    bus_read(2'd1, 4);
    bus_read(2'd3, 2);
    bus_write(2'd2, 8'h90, 2);

    for (int k = 0; k < 120; k++) begin
      if (cyc < CYC - 200) begin
        if ($urandom_range(0, 1) == 1)
          bus_write(2'($urandom_range(0, 3)), 8'($urandom), $urandom_range(1, 4));
        else
          bus_read(2'($urandom_range(0, 3)), $urandom_range(1, 4));
      end
    end

    bus_conflict();
    reset_in_flight();
    bus_write(2'd0, 8'h12, 2);
    bus_write(2'd3, 8'hDE, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
